// File: rtl/cipher_round_engine.sv
// Iterative multi-round cipher core: one full round per clock, valid/ready on both sides.
// Block is LANES x 32-bit words; the nibble S-box runs per lane, the byte permutes span the block.

module cre_sbox_lane (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   for (genvar g = 0; g < 8; g++) begin : g_nib
      assign word_o[4*g +: 4] = sbox4(word_i[4*g +: 4]);
   end

endmodule

module cipher_round_engine #(
   parameter int LANES  = 4,
   parameter int ROUNDS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [32*LANES-1:0]   in_data,
   input  logic [31:0]           in_key,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*LANES-1:0]   out_data,
   output logic                  busy,
   output logic [7:0]            round_idx
);

   localparam int NB = 4 * LANES;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                  fsm_q, fsm_d;
   logic [LANES-1:0][31:0]  st_q, st_d;
   logic [31:0]             key_q, key_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    alive_q;

   // ---------------- round datapath ----------------
   logic [31:0]             mix_t;
   logic [LANES-1:0][31:0]  s1, s2w, s3, s4w, s5, nxt;
   logic [NB-1:0][7:0]      s1b, s2b, s3b, s4b;
   logic [31:0]             rk;
   logic [5:0]              rsh;

   always_comb begin
      mix_t = '0;
      for (int i = 0; i < LANES; i++) mix_t ^= st_q[i];
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) s1[i] = st_q[i] ^ mix_t;
   end

   assign s1b = s1;

   always_comb begin
      for (int j = 0; j < NB; j++) s2b[j] = s1b[NB-1-j];
   end

   assign s2w = s2b;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cre_sbox_lane u_sbox (
         .word_i (s2w[g]),
         .word_o (s3[g])
      );
   end

   assign s3b = s3;

   always_comb begin
      for (int j = 0; j < NB; j++) s4b[j] = s3b[NB-1-j];
   end

   assign s4w = s4b;

   // Round key: rotate base key left by (cnt mod 32), then fold in the round number.
   assign rsh = 6'd32 - {1'b0, cnt_q[4:0]};
   assign rk  = ((key_q << cnt_q[4:0]) | (key_q >> rsh)) ^ {24'd0, cnt_q};

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         s5[i]  = {s4w[i][15:0], s4w[i][31:16]};
         nxt[i] = s5[i] ^ rk;
      end
   end

   // ---------------- control ----------------
   always_comb begin
      fsm_d    = fsm_q;
      st_d     = st_q;
      key_d    = key_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = alive_q;
            if (in_valid && alive_q) begin
               st_d  = in_data;
               key_d = in_key;
               cnt_d = 8'd0;
               fsm_d = RUN;
            end
         end
         RUN: begin
            st_d  = nxt;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(ROUNDS-1)) fsm_d = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  st_d  = in_data;
                  key_d = in_key;
                  cnt_d = 8'd0;
                  fsm_d = RUN;
               end else begin
                  fsm_d = IDLE;
               end
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // alive_q keeps in_ready low through reset and sets on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         st_q    <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         alive_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         st_q    <= st_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         alive_q <= 1'b1;
      end
   end

   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == RUN);
   assign round_idx = busy ? cnt_q : 8'd0;
   assign out_data  = out_valid ? st_q : '0;

endmodule

// File: tb/tb_cipher_round_engine.sv
// Bench for cipher_round_engine: five parameterisations checked against a byte-level reference model.

module tb_cipher_round_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [4:0]         vld, ordy, irdy, ovld, bsy;
   logic [4:0][255:0]  din, dout;
   logic [4:0][31:0]   key;
   logic [4:0][7:0]    ridx;
   logic [127:0]       d0, d1, d2;
   logic [31:0]        d3;

   int LN[5] = '{4, 4, 4, 1, 8};
   int RN[5] = '{1, 2, 16, 255, 255};
   logic [3:0] SB[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   int ntests = 0;
   int nfail  = 0;

   cipher_round_engine #(.LANES(4), .ROUNDS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(irdy[0]), .in_data(din[0][127:0]),
      .in_key(key[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(d0), .busy(bsy[0]),
      .round_idx(ridx[0]));
   cipher_round_engine #(.LANES(4), .ROUNDS(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(irdy[1]), .in_data(din[1][127:0]),
      .in_key(key[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(d1), .busy(bsy[1]),
      .round_idx(ridx[1]));
   cipher_round_engine #(.LANES(4), .ROUNDS(16)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(irdy[2]), .in_data(din[2][127:0]),
      .in_key(key[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_data(d2), .busy(bsy[2]),
      .round_idx(ridx[2]));
   cipher_round_engine #(.LANES(1), .ROUNDS(255)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(irdy[3]), .in_data(din[3][31:0]),
      .in_key(key[3]), .out_valid(ovld[3]), .out_ready(ordy[3]), .out_data(d3), .busy(bsy[3]),
      .round_idx(ridx[3]));
   cipher_round_engine #(.LANES(8), .ROUNDS(255)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[4]), .in_ready(irdy[4]), .in_data(din[4]),
      .in_key(key[4]), .out_valid(ovld[4]), .out_ready(ordy[4]), .out_data(dout[4]), .busy(bsy[4]),
      .round_idx(ridx[4]));

   assign dout[0] = {128'd0, d0};
   assign dout[1] = {128'd0, d1};
   assign dout[2] = {128'd0, d2};
   assign dout[3] = {224'd0, d3};

   // Reference: works on a byte list and a lookup table, straight from the round rules.
   function automatic logic [255:0] model(int lanes, int rounds, logic [255:0] data, logic [31:0] k);
      logic [31:0]  w[8];
      logic [7:0]   b[32];
      logic [7:0]   rb[32];
      logic [31:0]  t, rk;
      logic [255:0] res;
      int nb, sh;
      nb = 4 * lanes;
      for (int i = 0; i < lanes; i++) w[i] = data[32*i +: 32];
      for (int r = 0; r < rounds; r++) begin
         t = 32'd0;
         for (int i = 0; i < lanes; i++) t ^= w[i];
         for (int i = 0; i < lanes; i++) w[i] ^= t;
         for (int j = 0; j < nb; j++) b[j] = w[j/4][8*(j%4) +: 8];
         for (int j = 0; j < nb; j++) rb[j] = b[nb-1-j];
         for (int j = 0; j < nb; j++) rb[j] = {SB[rb[j][7:4]], SB[rb[j][3:0]]};
         for (int j = 0; j < nb; j++) b[j] = rb[nb-1-j];
         sh = r % 32;
         rk = (sh == 0) ? k : ((k << sh) | (k >> (32 - sh)));
         rk ^= 32'(r);
         for (int i = 0; i < lanes; i++) begin
            w[i] = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            w[i] = {w[i][15:0], w[i][31:16]} ^ rk;
         end
      end
      res = '0;
      for (int i = 0; i < lanes; i++) res[32*i +: 32] = w[i];
      return res;
   endfunction

   function automatic logic [255:0] rnd_block(int lanes);
      logic [255:0] d;
      d = '0;
      for (int i = 0; i < lanes; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send(input int i, input logic [255:0] d, input logic [31:0] k, input string nm);
      int n = 0;
      while (!irdy[i] && n < 50) begin @(posedge clk); #1; n++; end
      if (!irdy[i]) chk({nm, " in_ready timeout"}, 256'(irdy[i]), 256'd1);
      din[i] = d; key[i] = k; vld[i] = 1'b1;
      @(posedge clk); #1;
      vld[i] = 1'b0; din[i] = ~d; key[i] = ~k;
   endtask

   task automatic wait_out(input int i, input int lat, input string nm);
      int n = 0;
      while (!ovld[i] && n < lat + 20) begin @(posedge clk); #1; n++; end
      chk({nm, " latency"}, 256'(n), 256'(lat));
   endtask

   task automatic accept(input int i, input int hold, input logic [255:0] exp, input string nm);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({nm, " held data"}, dout[i], exp);
      end
      ordy[i] = 1'b1;
      @(posedge clk); #1;
      ordy[i] = 1'b0;
      chk({nm, " out_valid drop"}, 256'(ovld[i]), 256'd0);
   endtask

   task automatic run_one(input int i, input logic [255:0] d, input logic [31:0] k,
                          input logic [255:0] exp, input int lat, input int hold, input string nm);
      send(i, d, k, nm);
      wait_out(i, lat, nm);
      chk({nm, " data"}, dout[i], exp);
      accept(i, hold, exp, nm);
   endtask

   typedef struct {
      int           inst;
      logic [255:0] data;
      logic [31:0]  key;
      logic [255:0] exp;
      int           lat;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] a, b, ea, eb;
      int n, seen;
      rst_n = 1'b0; vld = '0; ordy = '0; din = '0; key = '0;

      tbl[0] = '{0, 256'd0, 32'd0, {128'd0, {4{32'hCCCCCCCC}}}, 1};
      tbl[1] = '{1, 256'd0, 32'd0, {128'd0, {4{32'h44444445}}}, 2};
      tbl[2] = '{0, {128'd0, 128'h01234567_89abcdef_fedcba98_76543210}, 32'hDEADBEEF, '0, 1};
      tbl[3] = '{1, rnd_block(4), $urandom, '0, 2};
      tbl[4] = '{2, 256'd0, 32'h00000001, '0, 16};
      tbl[5] = '{2, rnd_block(4), $urandom, '0, 16};
      for (int v = 2; v < 6; v++)
         tbl[v].exp = model(LN[tbl[v].inst], RN[tbl[v].inst], tbl[v].data, tbl[v].key);

      // reset state
      #2;
      chk("reset in_ready", 256'(irdy), 256'd0);
      chk("reset out_valid", 256'(ovld), 256'd0);
      chk("reset busy", 256'(bsy), 256'd0);
      chk("reset round_idx", 256'(ridx), 256'd0);
      chk("reset out_data u4", dout[4], 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("in_ready before first edge", 256'(irdy), 256'd0);
      @(posedge clk); #1;
      chk("in_ready after release", 256'(irdy), 256'h1f);

      // vector table
      for (int v = 0; v < 6; v++)
         run_one(tbl[v].inst, tbl[v].data, tbl[v].key, tbl[v].exp, tbl[v].lat, 0,
                 $sformatf("vec%0d", v));

      // backpressure: output held 10 cycles, input pulses ignored
      a = rnd_block(4); ea = model(4, 16, a, 32'h13579bdf);
      send(2, a, 32'h13579bdf, "bp");
      wait_out(2, 16, "bp");
      for (int c = 0; c < 10; c++) begin
         vld[2] = c[0]; din[2] = rnd_block(4);
         @(posedge clk); #1;
         chk($sformatf("bp data c%0d", c), dout[2], ea);
         chk($sformatf("bp in_ready c%0d", c), 256'(irdy[2]), 256'd0);
      end
      vld[2] = 1'b0;
      chk("bp out_valid held", 256'(ovld[2]), 256'd1);
      accept(2, 0, ea, "bp");
      chk("bp back to idle busy", 256'(bsy[2]), 256'd0);
      chk("bp back to idle in_ready", 256'(irdy[2]), 256'd1);

      // back-to-back: second block loads in DONE
      a = rnd_block(4); ea = model(4, 16, a, 32'hA5A5F00F);
      b = rnd_block(4); eb = model(4, 16, b, 32'h0BADCAFE);
      send(2, a, 32'hA5A5F00F, "b2b A");
      wait_out(2, 16, "b2b A");
      chk("b2b A data", dout[2], ea);
      din[2] = b; key[2] = 32'h0BADCAFE; vld[2] = 1'b1; ordy[2] = 1'b1;
      #1 chk("b2b in_ready follows out_ready", 256'(irdy[2]), 256'd1);
      @(posedge clk); #1;
      vld[2] = 1'b0; ordy[2] = 1'b0; din[2] = '0; key[2] = '0;
      chk("b2b busy next cycle", 256'(bsy[2]), 256'd1);
      chk("b2b out_valid low", 256'(ovld[2]), 256'd0);
      chk("b2b round_idx 0", 256'(ridx[2]), 256'd0);
      wait_out(2, 16, "b2b B");
      chk("b2b B data", dout[2], eb);
      accept(2, 0, eb, "b2b B");

      // reset in the middle of RUN
      send(2, rnd_block(4), $urandom, "rst");
      n = 0;
      while (ridx[2] != 8'd7 && n < 40) begin @(posedge clk); #1; n++; end
      chk("rst reached round 7", 256'(ridx[2]), 256'd7);
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", 256'(ovld), 256'd0);
      chk("rst busy", 256'(bsy), 256'd0);
      chk("rst in_ready", 256'(irdy), 256'd0);
      chk("rst round_idx", 256'(ridx[2]), 256'd0);
      chk("rst out_data", dout[2], 256'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst in_ready after release", 256'(irdy[2]), 256'd1);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (ovld[2] || bsy[2]) seen++;
         @(posedge clk); #1;
      end
      chk("rst no stale output", 256'(seen), 256'd0);

      // random scoreboard, LANES=1 and LANES=8 in parallel
      fork
         begin
            logic [255:0] d; logic [31:0] k;
            for (int blk = 0; blk < 40; blk++) begin
               d = rnd_block(1); k = $urandom;
               run_one(3, d, k, model(1, 255, d, k), 255, $urandom_range(0, 2),
                       $sformatf("sb1 blk%0d", blk));
            end
         end
         begin
            logic [255:0] d; logic [31:0] k;
            for (int blk = 0; blk < 40; blk++) begin
               d = rnd_block(8); k = $urandom;
               run_one(4, d, k, model(8, 255, d, k), 255, $urandom_range(0, 2),
                       $sformatf("sb8 blk%0d", blk));
            end
         end
      join

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
